// File: rtl/zikzak_pkg.sv
// Shared types and helpers for the zig-zag counter: FSM states, step phase,
// completion codes and the start-time configuration check.
package zikzak_pkg;

  typedef enum logic {
    BOS,
    SAY
  } durum_e;

  typedef enum logic {
    FAZ_ILERI,
    FAZ_GERI
  } faz_e;

  localparam logic [1:0] DURUM_SINIR = 2'd0;
  localparam logic [1:0] DURUM_IPTAL = 2'd1;
  localparam logic [1:0] DURUM_HATA  = 2'd2;

  // Arguments are widened by the caller so one helper serves any parameterisation.
  function automatic logic ayar_gecerli(
    input int unsigned bas,
    input int unsigned ileri,
    input int unsigned geri,
    input int unsigned alt,
    input int unsigned ust
  );
    return (ileri != 0) && (ileri > geri) && (alt <= ust) &&
           (bas >= alt) && (bas <= ust);
  endfunction

endpackage

// File: rtl/zikzak_adim_hesap.sv
// Combinational next-candidate computation for the zig-zag counter, with
// carry/borrow and bound checking done in one extra bit of width.
module zikzak_adim_hesap #(
  parameter int unsigned GENISLIK = 8,
  parameter int unsigned ADIM_GEN = 3
) (
  input  logic [GENISLIK-1:0] i_deger,
  input  logic [ADIM_GEN-1:0] i_adim,
  input  logic                i_ekle,
  input  logic [GENISLIK-1:0] i_alt,
  input  logic [GENISLIK-1:0] i_ust,
  output logic [GENISLIK-1:0] o_aday,
  output logic                o_aralikta
);

  logic [GENISLIK:0] w_genis;
  logic [GENISLIK:0] w_adim_genis;

  always_comb begin
    w_adim_genis = (GENISLIK+1)'(i_adim);
    w_genis      = i_ekle ? ({1'b0, i_deger} + w_adim_genis)
                          : ({1'b0, i_deger} - w_adim_genis);
    o_aday       = w_genis[GENISLIK-1:0];
    // The top bit catches both carry past all-ones and borrow below zero.
    o_aralikta   = !w_genis[GENISLIK] && (o_aday >= i_alt) && (o_aday <= i_ust);
  end

endmodule

// File: rtl/zikzak_sayac_p.sv
// Zig-zag counter with start/busy/done handshake, step count and status code.
// Optional pause input `duraklat` is enabled by defining ZIKZAK_DURAKLAT_EN.
module zikzak_sayac_p
  import zikzak_pkg::*;
#(
  parameter int unsigned GENISLIK = 8,
  parameter int unsigned ADIM_GEN = 3,
  parameter int unsigned SAYI_GEN = 16
) (
  input  logic                saat,
  input  logic                reset,
  input  logic                basla,
  input  logic                durdur,
`ifdef ZIKZAK_DURAKLAT_EN
  input  logic                duraklat,
`endif
  input  logic [GENISLIK-1:0] baslangic_degeri,
  input  logic [ADIM_GEN-1:0] ileri_adim,
  input  logic [ADIM_GEN-1:0] geri_adim,
  input  logic                yon,
  input  logic [GENISLIK-1:0] alt_sinir,
  input  logic [GENISLIK-1:0] ust_sinir,
  output logic [GENISLIK-1:0] sonuc,
  output logic                gecerli,
  output logic                mesgul,
  output logic                bitti,
  output logic [1:0]          durum,
  output logic [SAYI_GEN-1:0] adim_sayisi
);

  durum_e              r_st;
  faz_e                r_faz;
  logic [GENISLIK-1:0] r_sonuc;
  logic                r_gecerli;
  logic                r_mesgul;
  logic                r_bitti;
  logic [1:0]          r_durum;
  logic [SAYI_GEN-1:0] r_adim_sayisi;
  logic [ADIM_GEN-1:0] r_ileri;
  logic [ADIM_GEN-1:0] r_geri;
  logic                r_yon;
  logic [GENISLIK-1:0] r_alt;
  logic [GENISLIK-1:0] r_ust;

  logic [ADIM_GEN-1:0] w_adim;
  logic                w_ekle;
  logic [GENISLIK-1:0] w_aday;
  logic                w_aralikta;
  logic                w_ayar_ok;
  logic                w_duraklat;

`ifdef ZIKZAK_DURAKLAT_EN
  assign w_duraklat = duraklat;
`else
  assign w_duraklat = 1'b0;
`endif

  assign w_adim    = (r_faz == FAZ_ILERI) ? r_ileri : r_geri;
  assign w_ekle    = (r_faz == FAZ_ILERI) ? r_yon : ~r_yon;
  assign w_ayar_ok = ayar_gecerli(32'(baslangic_degeri), 32'(ileri_adim),
                                  32'(geri_adim), 32'(alt_sinir), 32'(ust_sinir));

  zikzak_adim_hesap #(
    .GENISLIK(GENISLIK),
    .ADIM_GEN(ADIM_GEN)
  ) u_adim_hesap (
    .i_deger   (r_sonuc),
    .i_adim    (w_adim),
    .i_ekle    (w_ekle),
    .i_alt     (r_alt),
    .i_ust     (r_ust),
    .o_aday    (w_aday),
    .o_aralikta(w_aralikta)
  );

  always_ff @(posedge saat) begin
    if (reset) begin
      r_st          <= BOS;
      r_faz         <= FAZ_ILERI;
      r_sonuc       <= '0;
      r_gecerli     <= 1'b0;
      r_mesgul      <= 1'b0;
      r_bitti       <= 1'b0;
      r_durum       <= '0;
      r_adim_sayisi <= '0;
      r_ileri       <= '0;
      r_geri        <= '0;
      r_yon         <= 1'b0;
      r_alt         <= '0;
      r_ust         <= '0;
    end else begin
      r_gecerli <= 1'b0;
      r_bitti   <= 1'b0;
      case (r_st)
        BOS: begin
          if (basla) begin
            if (w_ayar_ok) begin
              r_ileri       <= ileri_adim;
              r_geri        <= geri_adim;
              r_yon         <= yon;
              r_alt         <= alt_sinir;
              r_ust         <= ust_sinir;
              r_sonuc       <= baslangic_degeri;
              r_gecerli     <= 1'b1;
              r_mesgul      <= 1'b1;
              r_adim_sayisi <= SAYI_GEN'(1);
              r_durum       <= DURUM_SINIR;
              r_faz         <= FAZ_ILERI;
              r_st          <= SAY;
            end else begin
              r_bitti       <= 1'b1;
              r_durum       <= DURUM_HATA;
              r_adim_sayisi <= '0;
            end
          end
        end
        SAY: begin
          // Abort outranks both pause and the bound check.
          if (durdur) begin
            r_mesgul <= 1'b0;
            r_bitti  <= 1'b1;
            r_durum  <= DURUM_IPTAL;
            r_st     <= BOS;
          end else if (w_duraklat) begin
            r_st <= SAY;
          end else if (w_aralikta) begin
            r_sonuc   <= w_aday;
            r_gecerli <= 1'b1;
            if (r_adim_sayisi != '1) r_adim_sayisi <= r_adim_sayisi + 1'b1;
            if (r_geri != '0)
              r_faz <= (r_faz == FAZ_ILERI) ? FAZ_GERI : FAZ_ILERI;
          end else begin
            r_mesgul <= 1'b0;
            r_bitti  <= 1'b1;
            r_durum  <= DURUM_SINIR;
            r_st     <= BOS;
          end
        end
        default: r_st <= BOS;
      endcase
    end
  end

  assign sonuc       = r_sonuc;
  assign gecerli     = r_gecerli;
  assign mesgul      = r_mesgul;
  assign bitti       = r_bitti;
  assign durum       = r_durum;
  assign adim_sayisi = r_adim_sayisi;

`ifndef SYNTHESIS
  a_sinir_icinde: assert property (@(posedge saat) disable iff (reset)
    r_mesgul |-> ((r_sonuc >= r_alt) && (r_sonuc <= r_ust)));
  a_bitti_gecerli: assert property (@(posedge saat) disable iff (reset)
    !(r_bitti && r_gecerli));
`endif

endmodule

// File: tb/tb_zikzak_sayac_p.sv
// Directed bench for zikzak_sayac_p; outputs are packed as
// {sonuc, gecerli, mesgul, bitti, durum, adim_sayisi} for each comparison.
module tb_zikzak_sayac_p;

  logic        saat;
  logic        reset;
  logic        basla;
  logic        durdur;
  logic        duraklat;
  logic [7:0]  baslangic_degeri;
  logic [2:0]  ileri_adim;
  logic [2:0]  geri_adim;
  logic        yon;
  logic [7:0]  alt_sinir;
  logic [7:0]  ust_sinir;
  logic [7:0]  sonuc;
  logic        gecerli;
  logic        mesgul;
  logic        bitti;
  logic [1:0]  durum;
  logic [15:0] adim_sayisi;
  logic [28:0] obs;

  int errors;
  int checks;

  logic [7:0] exp_v [9];

  zikzak_sayac_p #(
    .GENISLIK(8),
    .ADIM_GEN(3),
    .SAYI_GEN(16)
  ) dut (
    .saat            (saat),
    .reset           (reset),
    .basla           (basla),
    .durdur          (durdur),
`ifdef ZIKZAK_DURAKLAT_EN
    .duraklat        (duraklat),
`endif
    .baslangic_degeri(baslangic_degeri),
    .ileri_adim      (ileri_adim),
    .geri_adim       (geri_adim),
    .yon             (yon),
    .alt_sinir       (alt_sinir),
    .ust_sinir       (ust_sinir),
    .sonuc           (sonuc),
    .gecerli         (gecerli),
    .mesgul          (mesgul),
    .bitti           (bitti),
    .durum           (durum),
    .adim_sayisi     (adim_sayisi)
  );

  assign obs = {sonuc, gecerli, mesgul, bitti, durum, adim_sayisi};

  initial saat = 1'b0;
  always #5 saat = ~saat;

  function automatic logic [28:0] pack(input logic [7:0] s, input logic g,
                                       input logic m, input logic b,
                                       input logic [1:0] d, input logic [15:0] a);
    return {s, g, m, b, d, a};
  endfunction

  task automatic tick();
    @(posedge saat);
    #1;
  endtask

  task automatic ayarla(input logic [7:0] bas, input logic [2:0] il,
                        input logic [2:0] ge, input logic y,
                        input logic [7:0] al, input logic [7:0] us);
    baslangic_degeri = bas;
    ileri_adim       = il;
    geri_adim        = ge;
    yon              = y;
    alt_sinir        = al;
    ust_sinir        = us;
  endtask

  task automatic test_reset();
    logic [28:0] e;
    reset = 1'b1;
    tick();
    tick();
    e = '0;
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset: got %h want %h", obs, e);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_idle: got %h want %h", obs, e);
    end
  endtask

  task automatic test_zikzak_up();
    logic [28:0] e;
    ayarla(8'd10, 3'd3, 3'd1, 1'b1, 8'd0, 8'd20);
    basla = 1'b1;
    tick();
    basla = 1'b0;
    // Inputs changed mid-count must be ignored.
    ileri_adim = 3'd7;
    ust_sinir  = 8'd0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      e = pack(exp_v[i], 1'b1, 1'b1, 1'b0, 2'd0, 16'(i + 1));
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL zikzak_up[%0d]: got %h want %h", i, obs, e);
      end
    end
    tick();
    e = pack(8'd18, 1'b0, 1'b0, 1'b1, 2'd0, 16'd9);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL zikzak_up_end: got %h want %h", obs, e);
    end
    tick();
    e = pack(8'd18, 1'b0, 1'b0, 1'b0, 2'd0, 16'd9);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL zikzak_up_after: got %h want %h", obs, e);
    end
  endtask

  task automatic test_down_no_back();
    logic [28:0] e;
    logic [7:0]  v [3];
    v[0] = 8'd5; v[1] = 8'd3; v[2] = 8'd1;
    ayarla(8'd5, 3'd2, 3'd0, 1'b0, 8'd0, 8'd255);
    basla = 1'b1;
    tick();
    basla = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      e = pack(v[i], 1'b1, 1'b1, 1'b0, 2'd0, 16'(i + 1));
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL down[%0d]: got %h want %h", i, obs, e);
      end
    end
    tick();
    e = pack(8'd1, 1'b0, 1'b0, 1'b1, 2'd0, 16'd3);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL down_borrow: got %h want %h", obs, e);
    end
  endtask

  task automatic test_carry();
    logic [28:0] e;
    tick();
    ayarla(8'd250, 3'd7, 3'd0, 1'b1, 8'd0, 8'd255);
    basla = 1'b1;
    tick();
    basla = 1'b0;
    e = pack(8'd250, 1'b1, 1'b1, 1'b0, 2'd0, 16'd1);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL carry_first: got %h want %h", obs, e);
    end
    tick();
    e = pack(8'd250, 1'b0, 1'b0, 1'b1, 2'd0, 16'd1);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL carry_end: got %h want %h", obs, e);
    end
    tick();
  endtask

  task automatic test_invalid();
    logic [28:0] e;
    logic [7:0]  t_bas [4];
    logic [2:0]  t_il  [4];
    logic [2:0]  t_ge  [4];
    logic [7:0]  t_al  [4];
    t_bas[0] = 8'd10; t_il[0] = 3'd2; t_ge[0] = 3'd2; t_al[0] = 8'd0;
    t_bas[1] = 8'd10; t_il[1] = 3'd0; t_ge[1] = 3'd0; t_al[1] = 8'd0;
    t_bas[2] = 8'd10; t_il[2] = 3'd3; t_ge[2] = 3'd1; t_al[2] = 8'd30;
    t_bas[3] = 8'd25; t_il[3] = 3'd3; t_ge[3] = 3'd1; t_al[3] = 8'd0;
    for (int i = 0; i < 4; i++) begin
      ayarla(t_bas[i], t_il[i], t_ge[i], 1'b1, t_al[i], 8'd20);
      basla = 1'b1;
      tick();
      basla = 1'b0;
      e = pack(8'd250, 1'b0, 1'b0, 1'b1, 2'd2, 16'd0);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL invalid[%0d]: got %h want %h", i, obs, e);
      end
      tick();
      e = pack(8'd250, 1'b0, 1'b0, 1'b0, 2'd2, 16'd0);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL invalid_after[%0d]: got %h want %h", i, obs, e);
      end
    end
  endtask

  task automatic test_abort();
    logic [28:0] e;
    ayarla(8'd10, 3'd3, 3'd1, 1'b1, 8'd0, 8'd20);
    basla = 1'b1;
    tick();
    basla = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      e = pack(exp_v[i], 1'b1, 1'b1, 1'b0, 2'd0, 16'(i + 1));
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL abort_run[%0d]: got %h want %h", i, obs, e);
      end
    end
    durdur = 1'b1;
    tick();
    e = pack(8'd12, 1'b0, 1'b0, 1'b1, 2'd1, 16'd3);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL abort: got %h want %h", obs, e);
    end
    tick();
    e = pack(8'd12, 1'b0, 1'b0, 1'b0, 2'd1, 16'd3);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL abort_idle: got %h want %h", obs, e);
    end
    durdur = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [28:0] e;
    ayarla(8'd5, 3'd2, 3'd0, 1'b0, 8'd0, 8'd255);
    basla = 1'b1;
    tick();
    e = pack(8'd5, 1'b1, 1'b1, 1'b0, 2'd0, 16'd1);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL b2b_start: got %h want %h", obs, e);
    end
    ayarla(8'd250, 3'd7, 3'd0, 1'b1, 8'd0, 8'd255);
    tick();
    tick();
    e = pack(8'd1, 1'b1, 1'b1, 1'b0, 2'd0, 16'd3);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL b2b_busy_ignored: got %h want %h", obs, e);
    end
    tick();
    e = pack(8'd1, 1'b0, 1'b0, 1'b1, 2'd0, 16'd3);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL b2b_done: got %h want %h", obs, e);
    end
    tick();
    basla = 1'b0;
    e = pack(8'd250, 1'b1, 1'b1, 1'b0, 2'd0, 16'd1);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL b2b_restart: got %h want %h", obs, e);
    end
    tick();
    e = pack(8'd250, 1'b0, 1'b0, 1'b1, 2'd0, 16'd1);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL b2b_second_done: got %h want %h", obs, e);
    end
  endtask

  task automatic test_reset_mid();
    logic [28:0] e;
    ayarla(8'd10, 3'd3, 3'd1, 1'b1, 8'd0, 8'd20);
    basla = 1'b1;
    tick();
    basla = 1'b0;
    tick();
    e = pack(8'd13, 1'b1, 1'b1, 1'b0, 2'd0, 16'd2);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_mid_run: got %h want %h", obs, e);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    e = '0;
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_mid: got %h want %h", obs, e);
    end
    tick();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_mid_idle: got %h want %h", obs, e);
    end
  endtask

`ifdef ZIKZAK_DURAKLAT_EN
  task automatic test_pause();
    logic [28:0] e;
    ayarla(8'd10, 3'd3, 3'd1, 1'b1, 8'd0, 8'd20);
    basla = 1'b1;
    tick();
    basla = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      e = pack(exp_v[i], 1'b1, 1'b1, 1'b0, 2'd0, 16'(i + 1));
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL pause_run[%0d]: got %h want %h", i, obs, e);
      end
      if (i == 3) begin
        duraklat = 1'b1;
        for (int k = 0; k < 4; k++) begin
          tick();
          e = pack(8'd15, 1'b0, 1'b1, 1'b0, 2'd0, 16'd4);
          checks++;
          if (obs !== e) begin
            errors++;
            $display("FAIL pause_hold[%0d]: got %h want %h", k, obs, e);
          end
        end
        duraklat = 1'b0;
      end
    end
    tick();
    e = pack(8'd18, 1'b0, 1'b0, 1'b1, 2'd0, 16'd9);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL pause_end: got %h want %h", obs, e);
    end
  endtask
`endif

  initial begin
    errors   = 0;
    checks   = 0;
    reset    = 1'b1;
    basla    = 1'b0;
    durdur   = 1'b0;
    duraklat = 1'b0;
    ayarla(8'd0, 3'd0, 3'd0, 1'b0, 8'd0, 8'd0);
    exp_v[0] = 8'd10; exp_v[1] = 8'd13; exp_v[2] = 8'd12;
    exp_v[3] = 8'd15; exp_v[4] = 8'd14; exp_v[5] = 8'd17;
    exp_v[6] = 8'd16; exp_v[7] = 8'd19; exp_v[8] = 8'd18;

    test_reset();
    test_zikzak_up();
    test_down_no_back();
    test_carry();
    test_invalid();
    test_abort();
    test_back_to_back();
    test_reset_mid();
`ifdef ZIKZAK_DURAKLAT_EN
    test_pause();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/zikzak_sayac_p.md
Name: zikzak_sayac_p

Overview:
- Parametrised zig-zag counter, next generation of the team's forward/back stepping counter.
- Takes a start value, a major step, a minor back-step, a direction and programmable lower/upper bounds.
- Emits one value per cycle, alternating major and minor steps, until the next value would leave the bounds, an abort arrives, or the configuration is invalid.
- Sits behind a start/busy/done handshake, with a step counter and a completion-status code.

Parameters:
- GENISLIK, 8, width of value, bounds and result.
- ADIM_GEN, 3, width of the step inputs.
- SAYI_GEN, 16, width of the emitted-value counter.

Ports:
- saat  input  1  clock, rising edge.
- reset  input  1  reset, synchronous, active-high.
- basla  input  1  start request, sampled only while idle.
- durdur  input  1  abort request, sampled only while counting.
- baslangic_degeri  input  GENISLIK  start value.
- ileri_adim  input  ADIM_GEN  major step magnitude.
- geri_adim  input  ADIM_GEN  minor back-step magnitude.
- yon  input  1  direction: 1 = major step adds, minor subtracts; 0 = the opposite.
- alt_sinir  input  GENISLIK  inclusive lower bound.
- ust_sinir  input  GENISLIK  inclusive upper bound.
- sonuc  output  GENISLIK  current value.
- gecerli  output  1  one-cycle strobe: sonuc updated this cycle.
- mesgul  output  1  counting in progress.
- bitti  output  1  one-cycle completion pulse.
- durum  output  2  completion code, valid from the bitti pulse until the next start.
- adim_sayisi  output  SAYI_GEN  number of values emitted, saturating at all-ones.

Behaviour:
- Reset (synchronous, active-high, priority over everything, including mid-count): all outputs 0, state BOS, phase = major.
- States:
  - BOS: idle.
  - SAY: counting.
- All inputs are latched on start. Input changes during SAY have no effect.
- BOS + basla, config valid (cycle T), at T+1:
  - sonuc = baslangic_degeri, gecerli = 1, mesgul = 1, adim_sayisi = 1, durum = 0.
  - State SAY, phase = major.
- Config invalid when any of: ileri_adim == 0; ileri_adim <= geri_adim; alt_sinir > ust_sinir; baslangic_degeri outside [alt, ust].
- Invalid config: at T+1 bitti = 1, durum = 2, gecerli = 0, mesgul = 0, sonuc unchanged, adim_sayisi = 0; state stays BOS.
- SAY, each cycle:
  - Candidate = sonuc ± current step, computed in GENISLIK+1 bits. Carry or borrow counts as out of range.
  - Candidate within [alt, ust]: sonuc <= candidate, gecerli = 1, adim_sayisi increments.
  - Phase toggles after each emitted value. If geri_adim == 0, phase stays major.
  - Candidate out of range: sonuc holds, gecerli = 0, mesgul <= 0, bitti <= 1, durum <= 0, back to BOS.
- durdur in SAY takes priority over the bound check. Next edge: mesgul = 0, bitti = 1, durum = 1, sonuc holds.
- basla while mesgul = 1 is ignored. durdur in BOS is ignored.
- A new basla is accepted in the same cycle bitti is high, since the block is already in BOS.
- bitti and gecerli are never high in the same cycle.
- Debug invariant: sonuc stays within [alt, ust] while mesgul = 1.

Optional Feature:
- Macro: ZIKZAK_DURAKLAT_EN.
- Defined: adds input `duraklat` (1 bit).
  - While high in SAY: sonuc, phase and adim_sayisi are frozen, gecerli = 0, mesgul stays 1.
  - durdur still aborts while paused.
  - duraklat has no effect in BOS.
- Undefined: port absent; counting never stalls.

Decomposition:
- Package zikzak_pkg holds:
  - State encoding BOS/SAY.
  - durum codes: DURUM_SINIR = 0, DURUM_IPTAL = 1, DURUM_HATA = 2.
  - A config-check helper function.
- One natural sub-module, zikzak_adim_hesap: combinational candidate computation plus in-range check. Inputs: value, step, add/sub, bounds. Outputs: candidate, in-range flag.
- The FSM, counters and registers stay in the top module.

Test Plan:
- Zig-zag up: W=8, baslangic=10, ileri=3, geri=1, yon=1, alt=0, ust=20 → sonuc 10,13,12,15,14,17,16,19,18; then candidate 21 → bitti, durum=0, adim_sayisi=9.
- Down with no back-step: baslangic=5, ileri=2, geri=0, yon=0, bounds 0..255 → 5,3,1; then borrow → bitti, adim_sayisi=3.
- Carry boundary: baslangic=250, ileri=7, geri=0, yon=1, ust=255 → single value 250; candidate 257 detected via carry → bitti at T+2, adim_sayisi=1.
- Invalid config: ileri=2, geri=2 → bitti at T+1, durum=2, mesgul never 1, sonuc unchanged.
- Abort and reset:
  - durdur after 3 values of scenario 1 → next edge bitti, durum=1, sonuc=12.
  - reset mid-count in a rerun → all outputs 0 next edge.
  - basla during mesgul → ignored.
- With ZIKZAK_DURAKLAT_EN: duraklat held 4 cycles after sonuc=15 in scenario 1 → sonuc stays 15, gecerli=0, mesgul=1; resume continues 14,17,… and the final adim_sayisi is still 9.
